// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_ctrl_pkg
//   Shared constants and types for the instruction-fetch sequencer:
//   bus width, the NOP encoding presented to decode when nothing is valid,
//   the fetch FSM encodings and the {pc, inst} prefetch entry layout.
//   Optional build macro used by the top: RVX_FETCH_PERF_EN.

package inst_fetch_ctrl_pkg;

   // Width of instruction-memory addresses and instruction words.
   localparam int BUS_W = 32;

   // Canonical RISC-V NOP (addi x0, x0, 0), shown to decode on empty slots.
   localparam logic [BUS_W-1:0] NOP = 32'h0000_0013;

   // Sequential fetch advances one 32-bit word at a time.
   localparam logic [BUS_W-1:0] PC_STEP = 32'd4;

   // Clears the two byte-offset bits so fetch always stays word aligned.
   localparam logic [BUS_W-1:0] WORD_MASK = {{(BUS_W-2){1'b1}}, 2'b00};

   // Saturation point of the optional performance counters.
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   // Fetch FSM encodings.
   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_t;

   // One prefetch FIFO entry: the byte address and the word fetched there.
   typedef struct packed {
      logic [BUS_W-1:0] pc;
      logic [BUS_W-1:0] inst;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   // Word-align a redirect target; low misaligned bits are simply dropped.
   function automatic logic [BUS_W-1:0] align_word(input logic [BUS_W-1:0] addr);
      return addr & WORD_MASK;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == CNT_MAX) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fetch_fifo.sv
// fetch_fifo
//   Small synchronous FIFO holding prefetched {pc, inst} entries.
//   The head entry is read combinationally so decode sees it in the same
//   cycle it becomes valid; the array is small enough to live in LUTs.
//   flush empties the FIFO and overrides any push/pop in that cycle.
//   Pushes into a full FIFO and pops from an empty FIFO are ignored.
//   DEPTH must be a power of two (2 or 4 in this design) so the pointers
//   wrap naturally.

module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && (count_reg < CNT_W'(DEPTH));
   assign pop_ok  = pop && (count_reg != '0);

   // Occupancy after this cycle's accepted push/pop (flush handled in the register).
   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Pointer and occupancy registers; flush wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_next;
      end
   end

   // Entry storage; contents need no reset because occupancy gates their use.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   assign count = count_reg;
   assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
//   Instruction-fetch sequencer. Owns the fetch PC, drives the instruction
//   memory address every cycle, captures the combinationally returned word
//   into a prefetch FIFO and presents {pc, inst} to decode with valid/ready.
//   Redirects flush the FIFO and restart fetch; halt stops new fetches while
//   already-fetched entries still drain.
//   Optional macro RVX_FETCH_PERF_EN adds fetchCnt/stallCnt counters.
//   The fetch decision never looks at instReady, so there is no
//   combinational path from decode back to imAddrOut.

module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
#(
   parameter logic [BUS_W-1:0] RESET_PC   = '0,
   parameter int               FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [BUS_W-1:0] imAddrOut,
   input  logic [BUS_W-1:0] instIn,
   input  logic             fetchEn,
   input  logic             haltIn,
   input  logic             redirectValid,
   input  logic [BUS_W-1:0] redirectPc,
   output logic             instValid,
   input  logic             instReady,
   output logic [BUS_W-1:0] instOut,
   output logic [BUS_W-1:0] pcOut,
   output logic             halted
`ifdef RVX_FETCH_PERF_EN
   ,
   output logic [31:0]      fetchCnt,
   output logic [31:0]      stallCnt
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   fetch_state_t     state_reg;
   logic [BUS_W-1:0] pc_reg;
   logic             halted_reg;

   logic [CNT_W-1:0] fifo_count;
   logic [ENTRY_W-1:0] fifo_head_bits;
   fetch_entry_t     fifo_head;
   fetch_entry_t     push_entry;

   logic             redirect_take;
   logic             fifo_has_room;
   logic             fetch_fire;
   logic             head_valid;
   logic             pop_fire;

   // A redirect only acts once out of BOOT; in BOOT it is ignored entirely.
   assign redirect_take = redirectValid && (state_reg != FETCH_BOOT);

   // Room is judged on the registered count, before any same-cycle pop,
   // which keeps instReady out of the fetch decision.
   assign fifo_has_room = fifo_count < CNT_W'(FIFO_DEPTH);

   assign fetch_fire = (state_reg == FETCH_RUN) && fetchEn && !haltIn &&
                       !redirectValid && fifo_has_room;

   assign head_valid = (fifo_count != '0);

   // A redirect discards the head, so a concurrent handshake is not a pop.
   assign pop_fire = head_valid && instReady && !redirect_take;

   assign push_entry = '{pc: pc_reg, inst: instIn};

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fetch_fire),
      .pop   (pop_fire),
      .flush (redirect_take),
      .din   (push_entry),
      .count (fifo_count),
      .head  (fifo_head_bits)
   );

   assign fifo_head = fetch_entry_t'(fifo_head_bits);

   // Fetch FSM with the PC register and the registered halted flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= FETCH_BOOT;
         pc_reg     <= RESET_PC;
         halted_reg <= 1'b0;
      end else begin
         case (state_reg)
            FETCH_BOOT: begin
               state_reg <= FETCH_RUN;
            end
            FETCH_RUN: begin
               if (redirectValid) begin
                  pc_reg <= align_word(redirectPc);
               end else if (haltIn) begin
                  state_reg  <= FETCH_HALT;
                  halted_reg <= 1'b1;
               end else if (fetch_fire) begin
                  // Wraps silently at the top of the address space.
                  pc_reg <= pc_reg + PC_STEP;
               end
            end
            FETCH_HALT: begin
               if (redirectValid) begin
                  state_reg  <= FETCH_RUN;
                  halted_reg <= 1'b0;
                  pc_reg     <= align_word(redirectPc);
               end
            end
            default: begin
               state_reg  <= FETCH_BOOT;
               halted_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef RVX_FETCH_PERF_EN
   logic [31:0] fetch_cnt_reg;
   logic [31:0] stall_cnt_reg;

   // Saturating counts of pushes and of cycles where decode back-pressures.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (fetch_fire) begin
            fetch_cnt_reg <= sat_inc(fetch_cnt_reg);
         end
         if (head_valid && !instReady) begin
            stall_cnt_reg <= sat_inc(stall_cnt_reg);
         end
      end
   end

   assign fetchCnt = fetch_cnt_reg;
   assign stallCnt = stall_cnt_reg;
`endif

   assign imAddrOut = pc_reg;
   assign instValid = head_valid;
   assign instOut   = head_valid ? fifo_head.inst : NOP;
   assign pcOut     = head_valid ? fifo_head.pc   : '0;
   assign halted    = halted_reg;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl
//   Directed bench for inst_fetch_ctrl (RESET_PC=0, FIFO_DEPTH=2).
//   A queue-based reference model tracks the fetch PC, the FIFO contents
//   and the halted state; every cycle the outputs are compared against it.
//   Literal expectations along the directed sequence pin the model itself.

module tb_inst_fetch_ctrl;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_W  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imAddrOut;
   logic [31:0] instIn;
   logic        fetchEn;
   logic        haltIn;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        instValid;
   logic        instReady;
   logic [31:0] instOut;
   logic [31:0] pcOut;
   logic        halted;
`ifdef RVX_FETCH_PERF_EN
   logic [31:0] fetchCnt;
   logic [31:0] stallCnt;
`endif

   logic [31:0] mem_xor = 32'h0;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Memory returns a word derived from its address in the same cycle.
   assign instIn = imAddrOut ^ mem_xor;

   inst_fetch_ctrl #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imAddrOut     (imAddrOut),
      .instIn        (instIn),
      .fetchEn       (fetchEn),
      .haltIn        (haltIn),
      .redirectValid (redirectValid),
      .redirectPc    (redirectPc),
      .instValid     (instValid),
      .instReady     (instReady),
      .instOut       (instOut),
      .pcOut         (pcOut),
      .halted        (halted)
`ifdef RVX_FETCH_PERF_EN
      ,
      .fetchCnt      (fetchCnt),
      .stallCnt      (stallCnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc    = RST_PC;
   int          m_state = 0;            // 0 = boot, 1 = run, 2 = halted
   logic [31:0] m_fetch = 0;
   logic [31:0] m_stall = 0;

   always @(posedge clk) begin
      bit v;
      bit do_push;
      if (!rst_n) begin
         m_q.delete();
         m_pc    = RST_PC;
         m_state = 0;
         m_fetch = 0;
         m_stall = 0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else begin
         v = (m_q.size() > 0);
         if (v && !instReady && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (redirectValid) begin
            m_q.delete();
            m_pc    = redirectPc & 32'hFFFF_FFFC;
            m_state = 1;
         end else begin
            do_push = (m_state == 1) && fetchEn && !haltIn && (m_q.size() < DEPTH);
            if (v && instReady) void'(m_q.pop_front());
            if (do_push) begin
               m_q.push_back({m_pc, m_pc ^ mem_xor});
               m_pc = m_pc + 32'd4;
               if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
            end
            if (m_state == 1 && haltIn) m_state = 2;
         end
      end
      #2;
      check("model_imAddrOut", imAddrOut, m_pc);
      check("model_instValid", 32'(instValid), 32'(m_q.size() > 0));
      check("model_pcOut", pcOut, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
      check("model_instOut", instOut, (m_q.size() > 0) ? m_q[0].inst : NOP_W);
      check("model_halted", 32'(halted), 32'(m_state == 2));
`ifdef RVX_FETCH_PERF_EN
      check("model_fetchCnt", fetchCnt, m_fetch);
      check("model_stallCnt", stallCnt, m_stall);
`endif
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instValid"}, 32'(instValid), 32'h0);
      check({tag, "_instOut"}, instOut, NOP_W);
      check({tag, "_pcOut"}, pcOut, 32'h0);
      check({tag, "_imAddrOut"}, imAddrOut, RST_PC);
      check({tag, "_halted"}, 32'(halted), 32'h0);
`ifdef RVX_FETCH_PERF_EN
      check({tag, "_fetchCnt"}, fetchCnt, 32'h0);
      check({tag, "_stallCnt"}, stallCnt, 32'h0);
`endif
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b0; fetchEn = 1'b1; haltIn = 1'b0;
      redirectValid = 1'b0; redirectPc = 32'h0; instReady = 1'b1;

      // Reset and streaming at 1 instruction/cycle, word = address.
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);                               // edge 1: BOOT->RUN
      check("boot_no_valid", 32'(instValid), 32'h0);
      @(negedge clk);                               // edge 2: first push
      check("first_valid", 32'(instValid), 32'h1);
      check("first_pc", pcOut, 32'h0);
      check("first_inst", instOut, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check($sformatf("stream_pc%0d", k), pcOut, 32'(4 * k));
         check($sformatf("stream_inst%0d", k), instOut, 32'(4 * k));
      end

      // Back-pressure: FIFO fills in two pushes, then fetch stalls at pc=8.
      rst_n = 1'b0; instReady = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);                    // edges 1..4
      check("stall_addr_e4", imAddrOut, 32'h8);
      check("stall_head_e4", pcOut, 32'h0);
      repeat (2) @(negedge clk);                    // edges 5..6
      check("stall_addr_e6", imAddrOut, 32'h8);
`ifdef RVX_FETCH_PERF_EN
      check("stall_cnt", stallCnt, 32'd4);
      check("fetch_cnt", fetchCnt, 32'd2);
`endif
      instReady = 1'b1;
      check("drain_pc0", pcOut, 32'h0);
      @(negedge clk);
      check("drain_pc4", pcOut, 32'h4);
      @(negedge clk);
      check("drain_pc8", pcOut, 32'h8);

      // Redirect with a full FIFO and instReady high.
      mem_xor = 32'h5A5A_0000;
      instReady = 1'b0;
      @(negedge clk);
      redirectValid = 1'b1; redirectPc = 32'h0000_0103; instReady = 1'b1;
      @(negedge clk);
      check("redir_flush_valid", 32'(instValid), 32'h0);
      check("redir_aligned_pc", imAddrOut, 32'h100);
      redirectValid = 1'b0;
      @(negedge clk);
      check("redir_first_pc", pcOut, 32'h100);
      check("redir_first_inst", instOut, 32'h5A5A_0100);

      // Halt pulse with one entry queued: entry drains, fetch stops.
      haltIn = 1'b1; instReady = 1'b0;
      @(negedge clk);
      check("halt_flag", 32'(halted), 32'h1);
      check("halt_keeps_entry", pcOut, 32'h100);
      haltIn = 1'b0; instReady = 1'b1;
      @(negedge clk);
      check("halt_drained", 32'(instValid), 32'h0);
      repeat (2) @(negedge clk);
      check("halt_sticky", 32'(halted), 32'h1);
      check("halt_no_fetch", imAddrOut, 32'h104);
      redirectValid = 1'b1; redirectPc = 32'h40;
      @(negedge clk);
      check("resume_running", 32'(halted), 32'h0);
      redirectValid = 1'b0;
      @(negedge clk);
      check("resume_pc", pcOut, 32'h40);

      // PC wrap at the top of the address space.
      redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirectValid = 1'b0;
      check("wrap_addr", imAddrOut, 32'hFFFF_FFFC);
      @(negedge clk);
      check("wrap_pc_top", pcOut, 32'hFFFF_FFFC);
      @(negedge clk);
      check("wrap_pc_zero", pcOut, 32'h0);
      check("wrap_inst_zero", instOut, 32'h5A5A_0000);

      // fetchEn low: no pushes, pc holds.
      fetchEn = 1'b0;
      repeat (2) @(negedge clk);
      check("fetchen_off_valid", 32'(instValid), 32'h0);
      check("fetchen_off_addr", imAddrOut, 32'h4);
      fetchEn = 1'b1; instReady = 1'b0;
      repeat (2) @(negedge clk);                    // FIFO now full
      check("full_head", pcOut, 32'h4);

      // Asynchronous reset mid-cycle with the FIFO full; redirect in BOOT ignored.
      #2;
      rst_n = 1'b0; redirectValid = 1'b1; redirectPc = 32'h200;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);                               // edge 1, redirect ignored
      check("boot_redirect_ignored", imAddrOut, RST_PC);
      redirectValid = 1'b0; instReady = 1'b1;
      @(negedge clk);
      check("reboot_first_pc", pcOut, RST_PC);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
